// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline boundaries: EX->MEM control and payload structs.
// Optional 2-deep buffering in ex_mem_pipe_stage is enabled by defining EX_MEM_SKID_EN.
package rv_pipe_pkg;

  localparam int XLEN_D      = 32;
  localparam int REG_AW_D    = 5;
  localparam int RES_SRC_W_D = 2;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic [RES_SRC_W_D-1:0] result_src;
  } ex_mem_ctrl_t;

  typedef struct packed {
    ex_mem_ctrl_t        ctrl;
    logic [XLEN_D-1:0]   alu;
    logic [XLEN_D-1:0]   wdata;
    logic [XLEN_D-1:0]   pc4;
    logic [REG_AW_D-1:0] rd;
  } ex_mem_pay_t;

  localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '0;
  localparam int EX_MEM_PAY_W = $bits(ex_mem_pay_t);

endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM boundary bundle. slave = the pipeline stage, master = the EX/MEM environment.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// valid never depends on ready, and a stalled output (valid && !ready) keeps its payload stable.
interface ex_mem_pipe_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int RES_SRC_W = 2,
  parameter int CNT_W     = 16
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic [RES_SRC_W-1:0] ResultSrcE;
  logic [XLEN-1:0]      ALUResult;
  logic [XLEN-1:0]      RD2E;
  logic [XLEN-1:0]      PCPlus4E;
  logic [REG_AW-1:0]    RdE;
  logic                 out_valid;
  logic                 out_ready;
  logic                 RegWriteM;
  logic                 MemWriteM;
  logic [RES_SRC_W-1:0] ResultSrcM;
  logic [XLEN-1:0]      ALUResultM;
  logic [XLEN-1:0]      WriteDataM;
  logic [XLEN-1:0]      PCPlus4M;
  logic [REG_AW-1:0]    RdM;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output flush, in_valid, RegWriteE, MemWriteE, ResultSrcE, ALUResult, RD2E, PCPlus4E, RdE,
           out_ready,
    input  in_ready, out_valid, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM, stall_cnt
  );

  modport slave (
    input  flush, in_valid, RegWriteE, MemWriteE, ResultSrcE, ALUResult, RD2E, PCPlus4E, RdE,
           out_ready,
    output in_ready, out_valid, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM, stall_cnt
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic one-entry payload holder with valid flag; clr empties it, load fills it, take drains it.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready flow control, flush and a saturating stall counter.
// Define EX_MEM_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module ex_mem_pipe_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_D,
  parameter int REG_AW    = REG_AW_D,
  parameter int RES_SRC_W = RES_SRC_W_D,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst,
  ex_mem_pipe_stage_if.slave bus
);

  ex_mem_pay_t      in_pay;
  ex_mem_pay_t      main_q;
  ex_mem_pay_t      main_d;
  logic             out_valid_q;
  logic             in_ready_int;
  logic             in_fire;
  logic             out_fire;
  logic             stall;
  logic             main_load;
  logic             main_refill;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    in_pay                 = '0;
    in_pay.ctrl.reg_write  = bus.RegWriteE;
    in_pay.ctrl.mem_write  = bus.MemWriteE;
    in_pay.ctrl.result_src = bus.ResultSrcE[RES_SRC_W-1:0];
    in_pay.alu             = bus.ALUResult[XLEN-1:0];
    in_pay.wdata           = bus.RD2E[XLEN-1:0];
    in_pay.pc4             = bus.PCPlus4E[XLEN-1:0];
    in_pay.rd              = bus.RdE[REG_AW-1:0];
  end

  assign in_fire  = bus.in_valid && in_ready_int;
  assign out_fire = out_valid_q && bus.out_ready;
  assign stall    = out_valid_q && !bus.out_ready;

`ifdef EX_MEM_SKID_EN
  logic                    skid_valid;
  logic                    skid_load;
  logic [EX_MEM_PAY_W-1:0] skid_dout;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready_int = !skid_valid;
  assign skid_load    = in_fire && out_valid_q && !bus.out_ready;
  assign main_refill  = out_fire && skid_valid;
  assign main_load    = in_fire && (!out_valid_q || out_fire);
  assign main_d       = main_refill ? ex_mem_pay_t'(skid_dout) : in_pay;

  pipe_skid_buf #(
    .W(EX_MEM_PAY_W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .load (skid_load),
    .take (main_refill),
    .din  (in_pay),
    .valid(skid_valid),
    .dout (skid_dout)
  );
`else
  assign in_ready_int = bus.out_ready || !out_valid_q;
  assign main_refill  = 1'b0;
  assign main_load    = in_fire;
  assign main_d       = in_pay;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else if (bus.flush) begin
      // Dropping the control bits keeps a flushed slot inert even if valid were misread.
      out_valid_q <= 1'b0;
      main_q.ctrl <= EX_MEM_CTRL_NOP;
    end else if (main_refill || main_load) begin
      out_valid_q <= 1'b1;
      main_q      <= main_d;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_q;
  assign bus.RegWriteM  = main_q.ctrl.reg_write && out_valid_q;
  assign bus.MemWriteM  = main_q.ctrl.mem_write && out_valid_q;
  assign bus.ResultSrcM = main_q.ctrl.result_src[RES_SRC_W-1:0];
  assign bus.ALUResultM = main_q.alu[XLEN-1:0];
  assign bus.WriteDataM = main_q.wdata[XLEN-1:0];
  assign bus.PCPlus4M   = main_q.pc4[XLEN-1:0];
  assign bus.RdM        = main_q.rd[REG_AW-1:0];
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage; a second instance with a 4-bit counter covers saturation.
module tb_ex_mem_pipe_stage;

`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   saw55  = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] t2_vals[3] = '{32'h10, 32'h20, 32'h30};

  ex_mem_pipe_stage_if #(.CNT_W(16)) bus ();
  ex_mem_pipe_stage_if #(.CNT_W(4))  bus4 ();

  ex_mem_pipe_stage #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  ex_mem_pipe_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.ALUResultM === 32'h55) saw55 = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] alu, input logic [4:0] rd,
                       input bit rw, input bit mw);
    bus.in_valid   = v;
    bus.ALUResult  = alu;
    bus.RD2E       = alu ^ 32'hFFFF_0000;
    bus.PCPlus4E   = 32'h100 + {27'd0, rd};
    bus.RdE        = rd;
    bus.RegWriteE  = rw;
    bus.MemWriteE  = mw;
    bus.ResultSrcE = 2'b01;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h99, 5'd7, 1'b1, 1'b1);
    bus4.flush = 1'b0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.RegWriteE = 1'b0; bus4.MemWriteE = 1'b0; bus4.ResultSrcE = '0;
    bus4.ALUResult = '0; bus4.RD2E = '0; bus4.PCPlus4E = '0; bus4.RdE = '0;

    // 1: reset with in_valid held high
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu", bus.ALUResultM, 0);
    chk("rst_rd", bus.RdM, 0);
    chk("rst_regw", bus.RegWriteM, 0);
    chk("rst_memw", bus.MemWriteM, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // 2: back-to-back stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t2_vals[i], 5'd1, 1'b1, 1'b0);
      exp_q.push_back(t2_vals[i]);
      step();
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_alu", bus.ALUResultM, exp_q.pop_front());
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("t2_drain", bus.out_valid, 0);

    // 3: stall with the stage full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    drive(1'b1, 32'hCAFE_0000, 5'd4, 1'b1, 1'b0);
    if (SKID) exp_q.push_back(32'hCAFE_0000);
    #1;
    chk("t3_in_ready_2nd", bus.in_ready, SKID);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("t3_in_ready_full", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_alu", bus.ALUResultM, exp_q[0]);
    end
    chk("t3_valid", bus.out_valid, 1);
    chk("t3_rd", bus.RdM, 3);
    chk("t3_stall_cnt", bus.stall_cnt, 4);
    bus.out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    chk("t3_next_valid", bus.out_valid, exp_q.size() != 0);
    if (bus.out_valid === 1'b1) chk("t3_next_alu", bus.ALUResultM, exp_q[0]);
    step();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk("t3_empty", bus.out_valid, 0);
    chk("t3_cnt_kept", bus.stall_cnt, 4);

    // 4: flush with a store in flight (and one skid entry when present)
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h44, 5'd5, 1'b1, 1'b1);
    step();
    chk("t4_memw_live", bus.MemWriteM, 1);
    chk("t4_regw_live", bus.RegWriteM, 1);
    chk("t4_rd", bus.RdM, 5);
    drive(1'b1, 32'h66, 5'd6, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_memw", bus.MemWriteM, 0);
    chk("t4_regw", bus.RegWriteM, 0);
    chk("t4_in_ready", bus.in_ready, 1);
    chk("t4_cnt_no_clear", bus.stall_cnt, 6);
    bus.out_ready = 1'b1;
    step();
    chk("t4_skid_dropped", bus.out_valid, 0);

    // 5: in_fire in the flush cycle is discarded
    saw55 = 1'b0;
    drive(1'b1, 32'h55, 5'd9, 1'b1, 1'b1);
    bus.flush = 1'b1;
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    chk("t5_valid", bus.out_valid, 0);
    step();
    step();
    step();
    chk("t5_never_55", saw55, 0);

    // 6: counter saturation on the 4-bit instance
    bus4.in_valid = 1'b1;
    bus4.ALUResult = 32'h1;
    step();
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) chk("t6_cnt_14", bus4.stall_cnt, 14);
    end
    chk("t6_cnt_sat", bus4.stall_cnt, 15);
    chk("t6_still_valid", bus4.out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
